serial_subtractor: RTL

- Bit-serial unsigned subtractor; computes a_in - b_in LSB-first, one bit per enabled cycle, using a registered borrow chain.
- Inverse-arithmetic companion to the registered adder primitives. Used by softmax/normalisation datapaths for max-subtraction and magnitude compare.
- Operands enter and results leave through valid/ready handshakes. The block holds one operation at a time.

---
 rtl/serial_subtractor.sv | 132 +++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
//------------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial unsigned subtractor (a_in - b_in), LSB first, one bit per enabled cycle.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ebl,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             out_valid_q, out_valid_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;
  logic             bit_d, br_next;
  logic [WIDTH-1:0] res_shift;

  // rst term keeps in_ready low for the whole time reset is held
  assign in_ready  = rst && ebl && (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign zero      = zero_q;

  assign bit_d     = a_q[0] ^ b_q[0] ^ br_q;
  assign br_next   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign res_shift = {bit_d, res_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    diff_d      = diff_q;
    cnt_d       = cnt_q;
    br_d        = br_q;
    out_valid_d = out_valid_q;
    borrow_d    = borrow_q;
    zero_d      = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a_in;
          b_d     = b_in;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (ebl) begin
          a_d   = a_q >> 1;
          b_d   = b_q >> 1;
          res_d = res_shift;
          br_d  = br_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            // results are published only here, so a partial result is never visible
            state_d     = DONE;
            out_valid_d = 1'b1;
            diff_d      = res_shift;
            borrow_d    = br_next;
            zero_d      = (res_shift == '0);
          end
        end
      end
      DONE: begin
        if (out_valid_q && out_ready && ebl) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      diff_q      <= '0;
      cnt_q       <= '0;
      br_q        <= 1'b0;
      out_valid_q <= 1'b0;
      borrow_q    <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      diff_q      <= diff_d;
      cnt_q       <= cnt_d;
      br_q        <= br_d;
      out_valid_q <= out_valid_d;
      borrow_q    <= borrow_d;
      zero_q      <= zero_d;
    end
  end

endmodule

`default_nettype wire
